// File: rtl/tdc_pkg.sv
// Shared types and width helper for the thermometer-code generator.
// Used by therm_code_gen and bin2therm.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } sweep_state_e;

    // A count must reach N itself, so one extra bit beyond clog2(N).
    function automatic int cw_f(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/bin2therm.sv
// Combinational binary-count to thermometer-code expander with saturation flag.
// Optional one-bubble swap of bits k-1/k when built with `THERM_BUBBLE_EN.
module bin2therm
    import tdc_pkg::*;
#(
    parameter int N  = 64,
    parameter int CW = cw_f(N)
) (
    input  logic [CW-1:0] cnt_i,
`ifdef THERM_BUBBLE_EN
    input  logic          bubble_en_i,
`endif
    output logic [N-1:0]  therm_o,
    output logic          sat_o
);

    logic bub;

    always_comb begin
        bub     = 1'b0;
        therm_o = '0;
        sat_o   = 1'b0;
`ifdef THERM_BUBBLE_EN
        bub = bubble_en_i && (cnt_i != '0) && (cnt_i < CW'(N));
`endif
        if (cnt_i > CW'(N)) begin
            therm_o = '1;
            sat_o   = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                therm_o[i] = (cnt_i > CW'(i));
                // Bubble: clear the top set bit, set the first clear bit above it.
                if (bub && (cnt_i == CW'(i + 1))) therm_o[i] = 1'b0;
                if (bub && (i > 0) && (cnt_i == CW'(i))) therm_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/therm_code_gen.sv
// Thermometer-code generator: single counts via handshake or a 0..N sweep FSM,
// registered output stage with valid/ready. Optional feature macro: THERM_BUBBLE_EN.
module therm_code_gen
    import tdc_pkg::*;
#(
    parameter int N = 64,
    localparam int CW = cw_f(N)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef THERM_BUBBLE_EN
    input  logic          bubble_en,
`endif
    input  logic          cnt_valid,
    output logic          cnt_ready,
    input  logic [CW-1:0] cnt,
    input  logic          sweep_start,
    output logic          sweep_busy,
    output logic          sweep_done,
    output logic          therm_valid,
    input  logic          therm_ready,
    output logic [N-1:0]  therm,
    output logic          sat
);

    sweep_state_e  state_q, state_d;
    logic [CW-1:0] s_q, s_d;
    logic [CW-1:0] src;
    logic [N-1:0]  therm_q, therm_d, exp_therm;
    logic          sat_q, sat_d, exp_sat;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          load_ok, load;

    assign load_ok   = !vld_q || therm_ready;
    assign cnt_ready = (state_q == IDLE) && load_ok;
    assign src       = (state_q == SWEEP) ? s_q : cnt;

    bin2therm #(.N(N), .CW(CW)) u_bin2therm (
        .cnt_i       (src),
`ifdef THERM_BUBBLE_EN
        .bubble_en_i (bubble_en),
`endif
        .therm_o     (exp_therm),
        .sat_o       (exp_sat)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                // A same-cycle count handshake still loads before the sweep begins.
                load = cnt_valid && load_ok;
                if (sweep_start) begin
                    state_d = SWEEP;
                    s_d     = '0;
                end
            end
            SWEEP: begin
                if (load_ok) begin
                    load = 1'b1;
                    if (s_q == CW'(N)) state_d = DRAIN;
                    else               s_d     = s_q + 1'b1;
                end
            end
            DRAIN: begin
                if (vld_q && therm_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d   = load ? 1'b1 : (therm_ready ? 1'b0 : vld_q);
        therm_d = load ? exp_therm : therm_q;
        sat_d   = load ? exp_sat   : sat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            therm_q <= '0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            therm_q <= therm_d;
            sat_q   <= sat_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign sweep_busy  = (state_q != IDLE);
    assign sweep_done  = done_q;
    assign therm_valid = vld_q;
    assign therm       = therm_q;
    assign sat         = sat_q;

endmodule
